// File: rtl/pll_lock_sequencer_if.sv
//======================================================================
// Module   : pll_lock_sequencer_if
// Brief    : PLL control and status bundle between the lock sequencer
//            and the pixel clock generator / consumer.
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       retry_req;
    logic       pll_resetb;
    logic       pix_rst;
    logic       ready;
    logic       failed;
    logic [2:0] retries;
    logic [7:0] lost_cnt;

    // Sequencer side
    modport master (
        input  pll_lock,
        input  retry_req,
        output pll_resetb,
        output pix_rst,
        output ready,
        output failed,
        output retries,
        output lost_cnt
    );

    // PLL / consumer side
    modport slave (
        output pll_lock,
        output retry_req,
        input  pll_resetb,
        input  pix_rst,
        input  ready,
        input  failed,
        input  retries,
        input  lost_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
//======================================================================
// Module   : pll_lock_sequencer
// Brief    : Pixel-clock PLL power-up / recovery controller: timed PLL
//            reset, lock wait with bounded retries, stable-lock release.
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  wire logic             clk_12m,
    input  wire logic             rst,
    pll_lock_sequencer_if.master  bus
);

    localparam int c_MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_MAX_CYC = (c_MAX_AB > STABLE_CYCLES) ? c_MAX_AB : STABLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC);

    // Retry register is wide enough for MAX_RETRIES; the port view saturates at 7.
    localparam int c_RET_BITS = $clog2(MAX_RETRIES + 1);
    localparam int c_RET_W    = (c_RET_BITS > 3) ? c_RET_BITS : 3;

    localparam logic [c_CNT_W-1:0] c_RST_LAST    = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST   = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_RET_W-1:0] c_RET_MAX     = c_RET_W'(MAX_RETRIES);
    localparam logic [c_RET_W-1:0] c_RET_ONE     = c_RET_W'(1);
    localparam logic [c_RET_W-1:0] c_RET_SAT     = c_RET_W'(7);

    localparam logic [2:0] c_ST_PLL_RST   = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_STABLE    = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_FAILED    = 3'd4;

    logic               r_sync_meta;
    logic               r_lock_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_RET_W-1:0] r_retries;
    logic [7:0]         r_lost_cnt;
    logic               r_pll_resetb;
    logic               r_pix_rst;
    logic               r_ready;
    logic               r_failed;

    logic [2:0]         w_state_nxt;
    logic               w_retry_inc;
    logic               w_retry_clr;
    logic               w_lost_inc;
    logic               w_timed;

    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        w_lost_inc  = 1'b0;
        case (r_state)
            c_ST_PLL_RST: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end
            end
            c_ST_WAIT_LOCK: begin
                // Lock takes priority over a timeout on the same cycle.
                if (r_lock_s) begin
                    w_state_nxt = c_ST_STABLE;
                end else if (r_cnt == c_LOCK_LAST) begin
                    if (r_retries == c_RET_MAX) begin
                        w_state_nxt = c_ST_FAILED;
                    end else begin
                        w_state_nxt = c_ST_PLL_RST;
                        w_retry_inc = 1'b1;
                    end
                end
            end
            c_ST_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt = c_ST_PLL_RST;
                    w_lost_inc  = 1'b1;
                    w_retry_clr = 1'b1;
                end
            end
            c_ST_FAILED: begin
                if (bus.retry_req) begin
                    w_state_nxt = c_ST_PLL_RST;
                    w_retry_clr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_PLL_RST;
            end
        endcase
    end

    assign w_timed = (r_state == c_ST_PLL_RST) || (r_state == c_ST_WAIT_LOCK) ||
                     (r_state == c_ST_STABLE);

    always_ff @(posedge clk_12m or posedge rst) begin
        if (rst) begin
            r_sync_meta  <= 1'b0;
            r_lock_s     <= 1'b0;
            r_state      <= c_ST_PLL_RST;
            r_cnt        <= '0;
            r_retries    <= '0;
            r_lost_cnt   <= '0;
            r_pll_resetb <= 1'b0;
            r_pix_rst    <= 1'b1;
            r_ready      <= 1'b0;
            r_failed     <= 1'b0;
        end else begin
            r_sync_meta <= bus.pll_lock;
            r_lock_s    <= r_sync_meta;
            r_state     <= w_state_nxt;

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_timed) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (w_retry_clr) begin
                r_retries <= '0;
            end else if (w_retry_inc) begin
                r_retries <= r_retries + c_RET_ONE;
            end

            if (w_lost_inc && (r_lost_cnt != 8'hFF)) begin
                r_lost_cnt <= r_lost_cnt + 8'd1;
            end

            // Outputs are decoded from the next state so they change with the state register.
            r_pll_resetb <= !((w_state_nxt == c_ST_PLL_RST) || (w_state_nxt == c_ST_FAILED));
            r_pix_rst    <= (w_state_nxt != c_ST_RUN);
            r_ready      <= (w_state_nxt == c_ST_RUN);
            r_failed     <= (w_state_nxt == c_ST_FAILED);
        end
    end

    assign bus.pll_resetb = r_pll_resetb;
    assign bus.pix_rst    = r_pix_rst;
    assign bus.ready      = r_ready;
    assign bus.failed     = r_failed;
    assign bus.retries    = (r_retries > c_RET_SAT) ? 3'd7 : r_retries[2:0];
    assign bus.lost_cnt   = r_lost_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
//======================================================================
// Module   : tb_pll_lock_sequencer
// Brief    : Scoreboard bench for pll_lock_sequencer with a timeline
//            reference model and directed plus random lock stimulus.
// Revision : 1.0 - initial release
//======================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    typedef struct packed {
        logic       pll_resetb;
        logic       pix_rst;
        logic       ready;
        logic       failed;
        logic [2:0] retries;
        logic [7:0] lost_cnt;
    } outv_t;

    logic clk_12m = 1'b0;
    logic rst;

    pll_lock_sequencer_if bus ();

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clk_12m (clk_12m),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_12m = ~clk_12m;

    int    n_tests = 0;
    int    n_fail  = 0;
    outv_t exp_q[$];

    // Reference model: phase plus absolute entry time, lock seen two edges late.
    int   m_phase, m_start, m_n, m_att, m_lost;
    logic m_d1, m_d2;

    function automatic outv_t model_out();
        outv_t v;
        v.pll_resetb = !((m_phase == PH_RST) || (m_phase == PH_FAIL));
        v.pix_rst    = (m_phase != PH_RUN);
        v.ready      = (m_phase == PH_RUN);
        v.failed     = (m_phase == PH_FAIL);
        v.retries    = (m_att > 7) ? 3'd7 : 3'(m_att);
        v.lost_cnt   = 8'(m_lost);
        return v;
    endfunction

    always @(posedge clk_12m or posedge rst) begin
        if (rst) begin
            m_phase = PH_RST; m_start = 0; m_n = 0; m_att = 0; m_lost = 0;
            m_d1 = 1'b0; m_d2 = 1'b0;
            exp_q.delete();
        end else begin : m_step
            logic seen;
            int   t;
            m_n  = m_n + 1;
            seen = m_d2;
            m_d2 = m_d1;
            m_d1 = bus.pll_lock;
            t    = m_n - m_start;
            case (m_phase)
                PH_RST:    if (t == RST_CYCLES) begin m_phase = PH_WAIT; m_start = m_n; end
                PH_WAIT: begin
                    if (seen) begin
                        m_phase = PH_STABLE; m_start = m_n;
                    end else if (t == LOCK_TIMEOUT) begin
                        if (m_att == MAX_RETRIES) m_phase = PH_FAIL;
                        else begin m_att = m_att + 1; m_phase = PH_RST; end
                        m_start = m_n;
                    end
                end
                PH_STABLE: begin
                    if (!seen) begin m_phase = PH_WAIT; m_start = m_n; end
                    else if (t == STABLE_CYCLES) begin m_phase = PH_RUN; m_start = m_n; end
                end
                PH_RUN: begin
                    if (!seen) begin
                        if (m_lost < 255) m_lost = m_lost + 1;
                        m_att = 0; m_phase = PH_RST; m_start = m_n;
                    end
                end
                default: begin
                    if (bus.retry_req) begin m_att = 0; m_phase = PH_RST; m_start = m_n; end
                end
            endcase
        end
        exp_q.push_back(model_out());
    end

    // Monitor: DUT presents a fresh output vector every cycle.
    always @(negedge clk_12m) begin
        outv_t a, e;
        a = {bus.pll_resetb, bus.pix_rst, bus.ready, bus.failed, bus.retries, bus.lost_cnt};
        n_tests = n_tests + 1;
        if (exp_q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_empty @%0t actual=%h", $time, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL outputs @%0t resetb/pix_rst/ready/failed/retries/lost actual=%b/%b/%b/%b/%0d/%0d required=%b/%b/%b/%b/%0d/%0d",
                         $time, a.pll_resetb, a.pix_rst, a.ready, a.failed, a.retries, a.lost_cnt,
                         e.pll_resetb, e.pix_rst, e.ready, e.failed, e.retries, e.lost_cnt);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_12m);
            #2;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests = n_tests + 1;
        if (act != req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s @%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_resetb"}, int'(bus.pll_resetb), 0);
        check({tag, "_pix_rst"},    int'(bus.pix_rst),    1);
        check({tag, "_ready"},      int'(bus.ready),      0);
        check({tag, "_failed"},     int'(bus.failed),     0);
        check({tag, "_retries"},    int'(bus.retries),    0);
        check({tag, "_lost_cnt"},   int'(bus.lost_cnt),   0);
    endtask

    // Sub-cycle reset pulse between clock edges; outputs must react immediately.
    task automatic async_pulse(input string tag);
        rst = 1'b1;
        #1;
        check_reset_values(tag);
        #1;
        rst = 1'b0;
    endtask

    task automatic edges_until(input int which, input int budget, output int k);
        k = 0;
        do begin
            step(1);
            k = k + 1;
        end while (!((which == 0) ? bus.ready : (which == 1) ? bus.failed : bus.pll_resetb) && k < budget);
    endtask

    task automatic wait_model(input int ph, input int t, input int budget);
        int k = 0;
        while (!(m_phase == ph && (m_n - m_start) == t) && k < budget) begin
            step(1);
            k = k + 1;
        end
        check("wait_model_reached", int'(m_phase == ph && (m_n - m_start) == t), 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog_timeout @%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst           = 1'b1;
        bus.pll_lock  = 1'b0;
        bus.retry_req = 1'b0;
        step(3);
        check_reset_values("reset_state");

        // 1: normal bring-up
        rst = 1'b0;
        edges_until(2, 40, k);
        check("bringup_resetb_low_edges", k, RST_CYCLES);
        step(5);
        bus.pll_lock = 1'b1;
        edges_until(0, 60, k);
        check("bringup_lock_to_ready", k, 2 + STABLE_CYCLES + 1);
        check("bringup_retries", int'(bus.retries), 0);

        // 2: glitch in STABLE, plus async reset from RUN
        async_pulse("async_in_run");
        wait_model(PH_STABLE, 5, 40);
        bus.pll_lock = 1'b0;
        step(3);
        check("glitch_retries", int'(bus.retries), 0);
        check("glitch_not_ready", int'(bus.ready), 0);
        bus.pll_lock = 1'b1;
        edges_until(0, 60, k);
        check("glitch_relock_to_ready", k, 2 + STABLE_CYCLES + 1);

        // 3: timeouts to failure
        bus.pll_lock = 1'b0;
        async_pulse("async_before_timeout");
        edges_until(1, 200, k);
        check("fail_edge", k, (MAX_RETRIES + 1) * (RST_CYCLES + LOCK_TIMEOUT));
        check("fail_retries", int'(bus.retries), MAX_RETRIES);
        step(10);
        check("fail_held", int'(bus.failed), 1);
        check("fail_resetb", int'(bus.pll_resetb), 0);
        check("fail_pix_rst", int'(bus.pix_rst), 1);

        // 4: recovery from FAILED, async reset in STABLE, retry ignored in RUN
        bus.pll_lock = 1'b1;
        step(3);
        check("fail_ignores_lock", int'(bus.failed), 1);
        bus.retry_req = 1'b1;
        step(1);
        bus.retry_req = 1'b0;
        check("recover_retries", int'(bus.retries), 0);
        check("recover_resetb", int'(bus.pll_resetb), 0);
        wait_model(PH_STABLE, 3, 40);
        async_pulse("async_in_stable");
        edges_until(0, 60, k);
        check("restart_to_ready", k, RST_CYCLES + 1 + STABLE_CYCLES);
        bus.retry_req = 1'b1;
        step(1);
        bus.retry_req = 1'b0;
        step(3);
        check("run_ignores_retry", int'(bus.ready), 1);

        // 5: repeated lock loss, lost_cnt saturation
        for (int i = 0; i < 260; i++) begin
            bus.pll_lock = 1'b0;
            step(2);
            if (i == 0) check("loss_still_run_edge2", int'(bus.ready), 1);
            step(1);
            check("loss_pix_rst_edge3", int'(bus.pix_rst), 1);
            check("loss_resetb_edge3", int'(bus.pll_resetb), 0);
            if (i == 0) check("loss_first_count", int'(bus.lost_cnt), 1);
            bus.pll_lock = 1'b1;
            edges_until(0, 40, k);
            check("loss_relock_ready", int'(bus.ready), 1);
        end
        check("lost_cnt_saturated", int'(bus.lost_cnt), 255);

        // Random lock/retry/reset activity checked by the scoreboard
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) async_pulse("async_random");
            bus.pll_lock = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                bus.retry_req = 1'b1;
                step(1);
                bus.retry_req = 1'b0;
            end
            step($urandom_range(1, 30));
        end

        step(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
